data_ram_ctrl: RTL

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

---
 rtl/data_ram_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// Word-addressed 32-bit data RAM for the MEM stage.
// Define DATA_RAM_WAIT_EN for the IDLE/WAIT/RESP wait-state machine; otherwise zero wait states.
module data_ram_ctrl #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic                  mem_we;
    logic                  unused_addr;

    assign idx         = addr_i[DEPTH_LOG2+1:2];
    assign rd_word     = mem_q[idx];
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    // Contents survive reset; mem_we already excludes rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= data_i;
        end
    end

`ifdef DATA_RAM_WAIT_EN

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        ready_o = 1'b0;
        data_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (ce_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (!ce_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ready_o = 1'b1;
                state_d = IDLE;
                if (!we_i) begin
                    data_o = rd_word;
                end else begin
                    // A dropped request aborts the write even in RESP.
                    mem_we = ce_i && !rst;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`else

    logic unused_cfg;

    assign unused_cfg = (WAIT_CYCLES == 0);

    always_comb begin
        ready_o = ce_i && !rst;
        data_o  = (ce_i && !we_i && !rst) ? rd_word : '0;
        mem_we  = ce_i && we_i && !rst;
    end

`endif

endmodule
